// File: rtl/ysyx_22040386_wbu_stage.sv
// MEM/WB boundary and write-back stage.
// A 2-entry skid buffer (head + skid) holds MEM results. The head entry is
// offered to the commit port and, on commit, written to the register file.
// An ebreak or illegal instruction halts the core until reset.
module ysyx_22040386_wbu_stage #(
  parameter int          XLEN   = 64,
  parameter int          CNT_W  = 64,
  parameter logic [31:0] EBREAK = 32'h00100073
) (
  input  logic             i_WB_clk,
  input  logic             i_WB_rst,
  input  logic             i_WB_valid,
  output logic             o_WB_ready,
  input  logic             i_WB_RegWrite,
  input  logic [4:0]       i_WB_reg_wr_addr,
  input  logic [XLEN-1:0]  i_WB_reg_wr_data,
  input  logic [63:0]      i_WB_pc,
  input  logic [31:0]      i_WB_inst,
  input  logic             i_WB_unkown_code,
  input  logic [XLEN-1:0]  i_WB_a0,
  output logic             o_WB_RegWrite,
  output logic [4:0]       o_WB_reg_wr_addr,
  output logic [XLEN-1:0]  o_WB_reg_wr_data,
  output logic             o_WB_commit_valid,
  input  logic             i_WB_commit_ready,
  output logic [63:0]      o_WB_commit_pc,
  output logic [31:0]      o_WB_commit_inst,
  output logic             o_WB_halt,
  output logic [XLEN-1:0]  o_WB_halt_code,
  output logic [CNT_W-1:0] o_WB_retire_cnt
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;

  logic             r_head_v, r_head_rw, r_head_unk;
  logic [4:0]       r_head_addr;
  logic [XLEN-1:0]  r_head_data;
  logic [63:0]      r_head_pc;
  logic [31:0]      r_head_inst;

  logic             r_skid_v, r_skid_rw, r_skid_unk;
  logic [4:0]       r_skid_addr;
  logic [XLEN-1:0]  r_skid_data;
  logic [63:0]      r_skid_pc;
  logic [31:0]      r_skid_inst;

  logic [CNT_W-1:0] r_retire_cnt;
  logic [XLEN-1:0]  r_halt_code;

  logic w_run, w_accept, w_fire, w_halting, w_to_head;

  assign w_run      = (r_state == S_RUN);
  assign o_WB_ready = w_run & ~r_skid_v;
  assign w_accept   = i_WB_valid & o_WB_ready;
  assign w_fire     = r_head_v & w_run & i_WB_commit_ready;
  assign w_halting  = w_fire & ((r_head_inst == EBREAK) | r_head_unk);
  // New entries go to head when head is empty or leaving this cycle.
  assign w_to_head  = ~r_head_v | w_fire;

  assign o_WB_commit_valid = r_head_v & w_run;
  // Illegal instructions never update architectural state.
  assign o_WB_RegWrite     = w_fire & r_head_rw & (r_head_addr != 5'd0) & ~r_head_unk;
  assign o_WB_reg_wr_addr  = r_head_v ? r_head_addr : 5'd0;
  assign o_WB_reg_wr_data  = r_head_v ? r_head_data : '0;
  assign o_WB_commit_pc    = r_head_v ? r_head_pc   : 64'd0;
  assign o_WB_commit_inst  = r_head_v ? r_head_inst : 32'd0;
  assign o_WB_halt         = (r_state == S_HALT);
  assign o_WB_halt_code    = r_halt_code;
  assign o_WB_retire_cnt   = r_retire_cnt;

  // State register.
  always_ff @(posedge i_WB_clk) begin
    if (i_WB_rst) r_state <= S_RUN;
    else          r_state <= w_state_nxt;
  end

  // Next state: a committing ebreak/illegal instruction halts; HALT is absorbing.
  always_comb begin
    w_state_nxt = r_state;
    if (w_run && w_halting) w_state_nxt = S_HALT;
  end

  // Head slot: load from input or from skid; cleared by halt.
  always_ff @(posedge i_WB_clk) begin
    if (i_WB_rst) begin
      r_head_v    <= 1'b0;
      r_head_rw   <= 1'b0;
      r_head_unk  <= 1'b0;
      r_head_addr <= 5'd0;
      r_head_data <= '0;
      r_head_pc   <= 64'd0;
      r_head_inst <= 32'd0;
    end else if (w_halting) begin
      r_head_v    <= 1'b0;
    end else if (w_fire && r_skid_v) begin
      r_head_v    <= 1'b1;
      r_head_rw   <= r_skid_rw;
      r_head_unk  <= r_skid_unk;
      r_head_addr <= r_skid_addr;
      r_head_data <= r_skid_data;
      r_head_pc   <= r_skid_pc;
      r_head_inst <= r_skid_inst;
    end else if (w_accept && w_to_head) begin
      r_head_v    <= 1'b1;
      r_head_rw   <= i_WB_RegWrite;
      r_head_unk  <= i_WB_unkown_code;
      r_head_addr <= i_WB_reg_wr_addr;
      r_head_data <= i_WB_reg_wr_data;
      r_head_pc   <= i_WB_pc;
      r_head_inst <= i_WB_inst;
    end else if (w_fire) begin
      r_head_v    <= 1'b0;
    end
  end

  // Skid slot: catches an accept while head is held; drains into head on commit.
  always_ff @(posedge i_WB_clk) begin
    if (i_WB_rst) begin
      r_skid_v    <= 1'b0;
      r_skid_rw   <= 1'b0;
      r_skid_unk  <= 1'b0;
      r_skid_addr <= 5'd0;
      r_skid_data <= '0;
      r_skid_pc   <= 64'd0;
      r_skid_inst <= 32'd0;
    end else if (w_halting || w_fire) begin
      r_skid_v    <= 1'b0;
    end else if (w_accept && !w_to_head) begin
      r_skid_v    <= 1'b1;
      r_skid_rw   <= i_WB_RegWrite;
      r_skid_unk  <= i_WB_unkown_code;
      r_skid_addr <= i_WB_reg_wr_addr;
      r_skid_data <= i_WB_reg_wr_data;
      r_skid_pc   <= i_WB_pc;
      r_skid_inst <= i_WB_inst;
    end
  end

  // Retired count and halt code; unknown opcode takes priority over ebreak.
  always_ff @(posedge i_WB_clk) begin
    if (i_WB_rst) begin
      r_retire_cnt <= '0;
      r_halt_code  <= '0;
    end else begin
      if (w_fire) r_retire_cnt <= r_retire_cnt + 1'b1;
      if (w_halting) r_halt_code <= r_head_unk ? {XLEN{1'b1}} : i_WB_a0;
    end
  end

endmodule
